// File: rtl/svm_sched_ctrl_if.sv
// Controller-side bundle for the SVM scheduler: trainer capture, test handshake,
// support-vector read channel, kernel response and classification result.
interface svm_sched_ctrl_if #(
   parameter int ADDR_W = 7,
   parameter int TERM_W = 12
);
   logic                     train_done;
   logic [ADDR_W-1:0]        sv_count;
   logic                     retrain;
   logic                     test_valid;
   logic [8:0]               test_x;
   logic                     test_ready;
   logic [8:0]               x_test_q;
   logic [1:0]               mem_opc;
   logic [ADDR_W-1:0]        mem_addr;
   logic                     kern_valid;
   logic signed [TERM_W-1:0] kern_term;
   logic                     class_valid;
   logic signed [1:0]        class_out;
   logic                     busy;
   logic                     err_empty;
   logic                     err_tmo;

   modport master (
      input  train_done, sv_count, retrain, test_valid, test_x, kern_valid, kern_term,
      output test_ready, x_test_q, mem_opc, mem_addr, class_valid, class_out, busy,
             err_empty, err_tmo
   );

   modport slave (
      output train_done, sv_count, retrain, test_valid, test_x, kern_valid, kern_term,
      input  test_ready, x_test_q, mem_opc, mem_addr, class_valid, class_out, busy,
             err_empty, err_tmo
   );
endinterface

// File: rtl/svm_sched_ctrl.sv
// SVM decision scheduler: one read per support vector, saturating accumulation of kernel
// terms, sign emitted as a one-cycle class pulse (2N+1 cycles with 1-cycle responses).
module svm_sched_ctrl #(
   parameter int                       ADDR_W = 7,
   parameter int                       TERM_W = 12,
   parameter int                       ACC_W  = 20,
   parameter logic signed [ACC_W-1:0]  BIAS   = '0,
   parameter int                       TMO    = 16
) (
   input  logic             clk,
   input  logic             resetn,
   svm_sched_ctrl_if.master bus
);

   localparam logic [1:0] OPC_IDLE = 2'b00;
   localparam logic [1:0] OPC_CAP  = 2'b01;
   localparam logic [1:0] OPC_READ = 2'b10;
   localparam int         CNT_W    = $clog2(TMO + 1);

   typedef enum logic [2:0] {
      S_CAPTURE,
      S_READY,
      S_ISSUE,
      S_WAIT,
      S_DECIDE
   } state_t;

   state_t                   st;
   logic signed [ACC_W-1:0]  acc;
   logic signed [ACC_W-1:0]  acc_sum;
   logic [ADDR_W-1:0]        idx;
   logic [ADDR_W-1:0]        n_sv;
   logic [CNT_W-1:0]         tmo_cnt;
   logic                     retrain_pend;
   logic                     idx_last;

   function automatic logic signed [ACC_W-1:0] sat_add(
      input logic signed [ACC_W-1:0]  a,
      input logic signed [TERM_W-1:0] t
   );
      logic [ACC_W:0] s;
      s = {a[ACC_W-1], a} + {{(ACC_W + 1 - TERM_W){t[TERM_W-1]}}, t};
      // Differing top two bits of the widened sum means the ACC_W-bit result overflowed.
      if (s[ACC_W] != s[ACC_W-1])
         sat_add = s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      else
         sat_add = s[ACC_W-1:0];
   endfunction

   function automatic logic [1:0] sign_of(input logic signed [ACC_W-1:0] v);
      return v[ACC_W-1] ? 2'b11 : 2'b01;
   endfunction

   assign acc_sum  = sat_add(acc, bus.kern_term);
   assign idx_last = (idx == n_sv - ADDR_W'(1));

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         st              <= S_CAPTURE;
         bus.test_ready  <= 1'b0;
         bus.x_test_q    <= '0;
         bus.mem_opc     <= OPC_CAP;
         bus.mem_addr    <= '0;
         bus.class_valid <= 1'b0;
         bus.class_out   <= '0;
         bus.busy        <= 1'b0;
         bus.err_empty   <= 1'b0;
         bus.err_tmo     <= 1'b0;
         acc             <= '0;
         idx             <= '0;
         n_sv            <= '0;
         tmo_cnt         <= '0;
         retrain_pend    <= 1'b0;
      end else begin
         bus.class_valid <= 1'b0;
         case (st)
            S_CAPTURE: begin
               if (bus.train_done) begin
                  n_sv           <= bus.sv_count;
                  bus.err_empty  <= (bus.sv_count == '0);
                  bus.mem_opc    <= OPC_IDLE;
                  bus.test_ready <= 1'b1;
                  st             <= S_READY;
               end
            end

            S_READY: begin
               // A retrain, fresh or deferred from a classification, beats any offered vector.
               if (retrain_pend || bus.retrain) begin
                  retrain_pend   <= 1'b0;
                  bus.err_empty  <= 1'b0;
                  bus.mem_opc    <= OPC_CAP;
                  bus.test_ready <= 1'b0;
                  st             <= S_CAPTURE;
               end else if (bus.test_valid && bus.test_ready) begin
                  bus.x_test_q   <= bus.test_x;
                  acc            <= BIAS;
                  idx            <= '0;
                  bus.test_ready <= 1'b0;
                  bus.busy       <= 1'b1;
                  if (n_sv == '0) begin
                     bus.class_valid <= 1'b1;
                     bus.class_out   <= sign_of(BIAS);
                     st              <= S_DECIDE;
                  end else begin
                     bus.mem_opc  <= OPC_READ;
                     bus.mem_addr <= '0;
                     st           <= S_ISSUE;
                  end
               end
            end

            S_ISSUE: begin
               if (bus.retrain)
                  retrain_pend <= 1'b1;
               tmo_cnt     <= '0;
               bus.mem_opc <= OPC_IDLE;
               st          <= S_WAIT;
            end

            S_WAIT: begin
               if (bus.retrain)
                  retrain_pend <= 1'b1;
               if (bus.kern_valid) begin
                  acc <= acc_sum;
                  if (idx_last) begin
                     bus.class_valid <= 1'b1;
                     bus.class_out   <= sign_of(acc_sum);
                     st              <= S_DECIDE;
                  end else begin
                     idx          <= idx + ADDR_W'(1);
                     bus.mem_opc  <= OPC_READ;
                     bus.mem_addr <= idx + ADDR_W'(1);
                     st           <= S_ISSUE;
                  end
               end else if (tmo_cnt == CNT_W'(TMO - 1)) begin
                  // Missing response: decide on whatever has been accumulated so far.
                  bus.err_tmo     <= 1'b1;
                  bus.class_valid <= 1'b1;
                  bus.class_out   <= sign_of(acc);
                  st              <= S_DECIDE;
               end else begin
                  tmo_cnt <= tmo_cnt + CNT_W'(1);
               end
            end

            S_DECIDE: begin
               retrain_pend   <= retrain_pend || bus.retrain;
               bus.test_ready <= !(retrain_pend || bus.retrain);
               bus.busy       <= 1'b0;
               st             <= S_READY;
            end

            default: begin
               bus.mem_opc    <= OPC_CAP;
               bus.test_ready <= 1'b0;
               bus.busy       <= 1'b0;
               st             <= S_CAPTURE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_svm_sched_ctrl.sv
// Bench for svm_sched_ctrl: directed scenarios plus randomized classifications checked
// against a saturating-sum reference model.
module tb_svm_sched_ctrl;
   localparam int AW   = 10;
   localparam int TW   = 12;
   localparam int AC   = 20;
   localparam int TMO  = 16;
   localparam int BIAS_I = -1;
   localparam int AMAX = (1 << (AC - 1)) - 1;
   localparam int AMIN = -(1 << (AC - 1));

   logic clk = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   svm_sched_ctrl_if #(.ADDR_W(AW), .TERM_W(TW)) bus ();

   svm_sched_ctrl #(
      .ADDR_W(AW), .TERM_W(TW), .ACC_W(AC), .BIAS(-20'sd1), .TMO(TMO)
   ) dut (
      .clk(clk),
      .resetn(resetn),
      .bus(bus)
   );

   int checks = 0;
   int failures = 0;
   int terms[$];
   bit exp_tmo = 1'b0;
   logic [8:0] last_x = '0;
   int last_addr = 0;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded its time budget");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic signed [63:0] obs,
                      input logic signed [63:0] want);
      checks++;
      assert (obs === want) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   function automatic int sat(input int a, input int t);
      int s;
      s = a + t;
      if (s > AMAX) return AMAX;
      if (s < AMIN) return AMIN;
      return s;
   endfunction

   // mode 0: uniform terms; mode 1: mostly max positive; mode 2: mostly max negative
   task automatic gen_terms(input int n, input int mode);
      int t;
      terms.delete();
      for (int i = 0; i < n; i++) begin
         t = int'($urandom_range(4095, 0)) - 2048;
         if (mode == 1 && $urandom_range(7, 0) != 0) t = 2047;
         if (mode == 2 && $urandom_range(7, 0) != 0) t = -2048;
         terms.push_back(t);
      end
   endtask

   task automatic capture(input int n);
      chk("cap_opc", bus.mem_opc, 1);
      chk("cap_ready", bus.test_ready, 0);
      bus.train_done = 1'b1;
      bus.sv_count   = AW'(n);
      step();
      bus.train_done = 1'b0;
      chk("cap_err_empty", bus.err_empty, (n == 0));
      chk("ready_opc", bus.mem_opc, 0);
      chk("ready_test_ready", bus.test_ready, 1);
   endtask

   task automatic classify(input int n, input int max_d, input int tmo_at,
                           input int ret_at, input bit chk_lat, input bit noise);
      int acc;
      int lat;
      int d;
      logic [8:0] x;
      acc = BIAS_I;
      x = 9'($urandom);
      chk("accept_ready", bus.test_ready, 1);
      bus.test_valid = 1'b1;
      bus.test_x     = x;
      step();
      lat = 1;
      bus.test_valid = 1'b0;
      bus.test_x     = 9'($urandom);
      last_x = x;
      chk("x_latched", bus.x_test_q, x);
      chk("busy_run", bus.busy, 1);
      for (int i = 0; i < n; i++) begin
         chk("issue_opc", bus.mem_opc, 2);
         chk("issue_addr", bus.mem_addr, i);
         last_addr = i;
         if (noise) begin
            bus.kern_valid = 1'b1;
            bus.kern_term  = 12'sh800;
         end
         step();
         lat++;
         bus.kern_valid = 1'b0;
         d = (i == tmo_at) ? TMO : int'($urandom_range(max_d, 0));
         for (int k = 0; k < d; k++) begin
            chk("wait_opc", bus.mem_opc, 0);
            chk("wait_addr_hold", bus.mem_addr, i);
            step();
            lat++;
         end
         if (i == tmo_at) begin
            exp_tmo = 1'b1;
            break;
         end
         bus.kern_valid = 1'b1;
         bus.kern_term  = TW'(terms[i]);
         if (i == ret_at) bus.retrain = 1'b1;
         acc = sat(acc, terms[i]);
         step();
         lat++;
         bus.kern_valid = 1'b0;
         bus.retrain    = 1'b0;
      end
      chk("decide_valid", bus.class_valid, 1);
      chk("decide_class", bus.class_out, (acc >= 0) ? 1 : -1);
      chk("decide_err_tmo", bus.err_tmo, exp_tmo);
      chk("decide_busy", bus.busy, 1);
      if (n > 0) chk("addr_hold", bus.mem_addr, last_addr);
      if (chk_lat) chk("latency", lat, 2 * n + 1);
      step();
      chk("pulse_end", bus.class_valid, 0);
      chk("class_hold", bus.class_out, (acc >= 0) ? 1 : -1);
      chk("busy_idle", bus.busy, 0);
      chk("ready_after", bus.test_ready, (ret_at >= 0) ? 0 : 1);
      if (ret_at >= 0) begin
         step();
         chk("pending_capture", bus.mem_opc, 1);
      end
   endtask

   initial begin
      int n;
      bus.train_done = 1'b0;
      bus.sv_count   = '0;
      bus.retrain    = 1'b0;
      bus.test_valid = 1'b0;
      bus.test_x     = '0;
      bus.kern_valid = 1'b0;
      bus.kern_term  = '0;
      step();
      step();
      chk("rst_opc", bus.mem_opc, 1);
      chk("rst_addr", bus.mem_addr, 0);
      chk("rst_ready", bus.test_ready, 0);
      chk("rst_x", bus.x_test_q, 0);
      chk("rst_cv", bus.class_valid, 0);
      chk("rst_class", bus.class_out, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_err_empty", bus.err_empty, 0);
      chk("rst_err_tmo", bus.err_tmo, 0);
      resetn = 1'b1;
      step();

      // Three SVs, fixed terms, 1-cycle responses
      capture(3);
      terms = '{5, -2, 1};
      classify(3, 0, -1, -1, 1'b1, 1'b0);

      // Retrain and test_valid together: retrain wins
      bus.retrain    = 1'b1;
      bus.test_valid = 1'b1;
      bus.test_x     = ~last_x;
      step();
      bus.retrain    = 1'b0;
      bus.test_valid = 1'b0;
      chk("tie_capture", bus.mem_opc, 1);
      chk("tie_x_kept", bus.x_test_q, last_x);
      chk("tie_busy", bus.busy, 0);

      // Empty model decides on the bias alone
      capture(0);
      terms.delete();
      classify(0, 0, -1, -1, 1'b1, 1'b0);

      // Retrain from READY clears err_empty
      bus.retrain = 1'b1;
      step();
      bus.retrain = 1'b0;
      chk("rt_capture", bus.mem_opc, 1);
      chk("rt_err_empty", bus.err_empty, 0);

      // Positive saturation must not wrap negative
      capture(512);
      terms.delete();
      for (int i = 0; i < 512; i++) terms.push_back(2047);
      classify(512, 0, -1, -1, 1'b1, 1'b0);

      // Timeout on the second read
      bus.retrain = 1'b1;
      step();
      bus.retrain = 1'b0;
      capture(4);
      gen_terms(4, 0);
      classify(4, 2, 1, -1, 1'b0, 1'b0);

      // Retrain during WAIT is deferred until the classification finishes
      gen_terms(4, 0);
      classify(4, 2, -1, 2, 1'b0, 1'b0);
      capture(5);
      gen_terms(5, 0);
      classify(5, 1, -1, -1, 1'b0, 1'b1);

      for (int it = 0; it < 10; it++) begin
         bus.retrain = 1'b1;
         step();
         bus.retrain = 1'b0;
         chk("loop_capture", bus.mem_opc, 1);
         chk("loop_err_empty", bus.err_empty, 0);
         n = (it == 3) ? 0 : int'($urandom_range(200, 1));
         capture(n);
         for (int r = 0; r < 2; r++) begin
            gen_terms(n, int'($urandom_range(2, 0)));
            classify(n, 3,
                     (n > 0 && $urandom_range(4, 0) == 0) ? int'($urandom_range(n - 1, 0)) : -1,
                     -1, 1'b0, 1'(($urandom_range(1, 0))));
         end
      end

      // Asynchronous reset while waiting for a kernel response
      gen_terms(3, 0);
      bus.test_valid = 1'b1;
      bus.test_x     = 9'h1a5;
      step();
      bus.test_valid = 1'b0;
      step();
      chk("pre_rst_wait", bus.mem_opc, 0);
      #2;
      resetn = 1'b0;
      #1;
      chk("arst_opc", bus.mem_opc, 1);
      chk("arst_addr", bus.mem_addr, 0);
      chk("arst_ready", bus.test_ready, 0);
      chk("arst_x", bus.x_test_q, 0);
      chk("arst_class", bus.class_out, 0);
      chk("arst_busy", bus.busy, 0);
      chk("arst_err_tmo", bus.err_tmo, 0);
      chk("arst_err_empty", bus.err_empty, 0);
      exp_tmo = 1'b0;
      bus.kern_valid = 1'b1;
      bus.kern_term  = 12'sd7;
      step();
      bus.kern_valid = 1'b0;
      chk("arst_no_pulse", bus.class_valid, 0);
      resetn = 1'b1;
      step();
      chk("post_rst_capture", bus.mem_opc, 1);
      capture(2);
      gen_terms(2, 0);
      classify(2, 0, -1, -1, 1'b1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
